// File: rtl/j1_irq_pkg.sv
// Shared register offsets, FSM state type and VECT field positions for the j1 interrupt controller.
package j1_irq_pkg;

  localparam logic [2:0] OFS_PEND = 3'd0;
  localparam logic [2:0] OFS_ENAB = 3'd2;
  localparam logic [2:0] OFS_EDGE = 3'd4;
  localparam logic [2:0] OFS_VECT = 3'd6;

  typedef enum logic {
    IDLE    = 1'b0,
    SERVICE = 1'b1
  } state_t;

  localparam int unsigned VALID_BIT = 15;

endpackage

// File: rtl/j1_irq_prio_enc.sv
// Lowest-index-first priority encoder: valid = |req, idx = position of the lowest set bit.
module j1_irq_prio_enc #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] req,
  output logic         valid,
  output logic [3:0]   idx
);

  always_comb begin
    valid = |req;
    idx   = '0;
    for (int unsigned i = N; i > 0; i--) begin
      if (req[i-1]) idx = 4'(i - 1);
    end
  end

endmodule

// File: rtl/j1_irq_ctrl.sv
// Prioritised interrupt controller on the j1 IO bus (PEND/ENAB/EDGE/VECT+EOI).
// Define J1_IRQ_NESTING_EN to replace the IDLE/SERVICE FSM with an in-service mask allowing preemption.
module j1_irq_ctrl #(
  parameter int unsigned NSRC        = 8,
  parameter logic [15:0] ADDR_BASE   = 16'h0800,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            resetq,
  input  logic            io_rd,
  input  logic            io_wr,
  input  logic [15:0]     io_addr,
  input  logic [15:0]     io_dout,
  output logic [15:0]     io_rdata,
  output logic            io_hit,
  input  logic [NSRC-1:0] irq_src,
  output logic            interrupt_request
);
  import j1_irq_pkg::*;

  logic [15:0]     ofs;
  logic [2:0]      sel;
  logic            wr_pend, wr_enab, wr_edge, wr_eoi, rd_vect;
  logic [NSRC-1:0] wdata;

  assign ofs    = io_addr - ADDR_BASE;
  assign io_hit = (ofs[15:3] == '0) && !ofs[0];
  assign sel    = {ofs[2:1], 1'b0};
  assign wdata  = NSRC'(io_dout);

  assign wr_pend = io_wr && io_hit && (sel == OFS_PEND);
  assign wr_enab = io_wr && io_hit && (sel == OFS_ENAB);
  assign wr_edge = io_wr && io_hit && (sel == OFS_EDGE);
  assign wr_eoi  = io_wr && io_hit && (sel == OFS_VECT);
  assign rd_vect = io_rd && io_hit && (sel == OFS_VECT);

  logic [NSRC-1:0] sync_q [SYNC_STAGES];
  logic [NSRC-1:0] hist, lvl, rise;
  logic [NSRC-1:0] pend, pend_n, en, edge_mode;

  assign lvl  = sync_q[SYNC_STAGES-1];
  assign rise = lvl & ~hist;

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      hist      <= '0;
      pend      <= '0;
      en        <= '0;
      edge_mode <= '0;
    end else begin
      sync_q[0] <= irq_src;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      hist <= lvl;
      pend <= pend_n;
      if (wr_enab) en <= wdata;
      if (wr_edge) edge_mode <= wdata;
    end
  end

  logic [NSRC-1:0] cand, best_oh;
  logic            valid, claim, req_n;
  logic [3:0]      best;
  logic [15:0]     vect;

  assign cand    = pend & en;
  assign best_oh = NSRC'(1) << best;

  j1_irq_prio_enc #(.N(NSRC)) u_best (
    .req   (cand),
    .valid (valid),
    .idx   (best)
  );

`ifdef J1_IRQ_NESTING_EN
  logic [NSRC-1:0] in_service, in_service_n, is_low_oh;
  logic            is_valid, grant;
  logic [3:0]      is_idx;

  j1_irq_prio_enc #(.N(NSRC)) u_in_service (
    .req   (in_service),
    .valid (is_valid),
    .idx   (is_idx)
  );

  assign is_low_oh = NSRC'(1) << is_idx;
  // Only a source strictly above the innermost active handler may be claimed.
  assign grant     = valid && (!is_valid || (best < is_idx));
  assign claim     = rd_vect && grant;
  assign req_n     = grant;
  assign vect      = grant ? {1'b1, 11'b0, best} : '0;

  always_comb begin
    in_service_n = in_service;
    if (wr_eoi && is_valid) in_service_n = in_service & ~is_low_oh;
    if (claim)              in_service_n = in_service | best_oh;
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) in_service <= '0;
    else         in_service <= in_service_n;
  end
`else
  state_t state_q, state_d;

  assign claim = rd_vect && (state_q == IDLE) && valid;
  assign req_n = (state_q == IDLE) && valid;
  assign vect  = {valid, 11'b0, best};

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (claim)  state_d = SERVICE;
      SERVICE: if (wr_eoi) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) state_q <= IDLE;
    else         state_q <= state_d;
  end
`endif

  // Clears first, then a new rising edge sets, so a same-cycle edge always survives.
  always_comb begin
    pend_n = pend;
    if (wr_pend) pend_n = pend_n & ~(edge_mode & wdata);
    if (claim)   pend_n = pend_n & ~(edge_mode & best_oh);
    pend_n = pend_n | (edge_mode & rise);
    pend_n = (pend_n & edge_mode) | (lvl & ~edge_mode);
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) interrupt_request <= 1'b0;
    else         interrupt_request <= req_n;
  end

  always_comb begin
    io_rdata = '0;
    if (io_hit) begin
      case (sel)
        OFS_PEND: io_rdata = 16'(pend);
        OFS_ENAB: io_rdata = 16'(en);
        OFS_EDGE: io_rdata = 16'(edge_mode);
        OFS_VECT: io_rdata = vect;
        default:  io_rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_j1_irq_ctrl.sv
// Scenario bench for j1_irq_ctrl: expected values queued at stimulus time, popped when observed.
module tb_j1_irq_ctrl;

  localparam logic [15:0] A_PEND = 16'h0800;
  localparam logic [15:0] A_ENAB = 16'h0802;
  localparam logic [15:0] A_EDGE = 16'h0804;
  localparam logic [15:0] A_VECT = 16'h0806;

  logic        clk = 1'b0;
  logic        resetq = 1'b0;
  logic        io_rd = 1'b0, io_wr = 1'b0;
  logic [15:0] io_addr = '0, io_dout = '0;
  logic [15:0] io_rdata;
  logic        io_hit;
  logic [7:0]  irq_src = '0;
  logic        interrupt_request;

  j1_irq_ctrl #(.NSRC(8), .ADDR_BASE(16'h0800), .SYNC_STAGES(2)) dut (
    .clk               (clk),
    .resetq            (resetq),
    .io_rd             (io_rd),
    .io_wr             (io_wr),
    .io_addr           (io_addr),
    .io_dout           (io_dout),
    .io_rdata          (io_rdata),
    .io_hit            (io_hit),
    .irq_src           (irq_src),
    .interrupt_request (interrupt_request)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] val;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          n_checks = 0;
  int          n_err = 0;
  logic [15:0] got;

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    io_wr = 1'b1; io_addr = a; io_dout = d;
    @(negedge clk);
    io_wr = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [15:0] d);
    @(negedge clk);
    io_rd = 1'b1; io_addr = a;
    #2 d = io_rdata;
    @(negedge clk);
    io_rd = 1'b0;
  endtask

  task automatic peek(input logic [15:0] a, output logic [15:0] d);
    io_addr = a;
    #1 d = io_rdata;
  endtask

  task automatic pulse(input logic [7:0] m);
    irq_src = irq_src | m;
    cycles(2);
    irq_src = irq_src & ~m;
    cycles(3);
  endtask

  task automatic test_reset;
    sb.push_back('{"rst_pend", 16'h0000}); peek(A_PEND, got); e = sb.pop_front(); n_checks++;
    if (got !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
    sb.push_back('{"rst_enab", 16'h0000}); peek(A_ENAB, got); e = sb.pop_front(); n_checks++;
    if (got !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
    sb.push_back('{"rst_vect", 16'h0000}); peek(A_VECT, got); e = sb.pop_front(); n_checks++;
    if (got !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
    sb.push_back('{"rst_req", 16'h0000}); got = {15'b0, interrupt_request}; e = sb.pop_front(); n_checks++;
    if (got !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
    sb.push_back('{"miss_rdata", 16'h0000}); io_addr = 16'h0808; #1 got = io_rdata; e = sb.pop_front(); n_checks++;
    if (got !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
    sb.push_back('{"miss_hit", 16'h0000}); got = {15'b0, io_hit}; e = sb.pop_front(); n_checks++;
    if (got !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
  endtask

  task automatic test_basic;
    bus_write(A_ENAB, 16'h0005);
    bus_write(A_EDGE, 16'h00FF);
    sb.push_back('{"enab_rd", 16'h0005}); bus_read(A_ENAB, got); e = sb.pop_front(); n_checks++;
    if (got !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
    irq_src[2] = 1'b1;
    cycles(1);
    cycles(1);
    irq_src[2] = 1'b0;
    sb.push_back('{"lat_req_t1", 16'h0000}); got = {15'b0, interrupt_request}; e = sb.pop_front(); n_checks++;
    if (got !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
    sb.push_back('{"lat_pend_t1", 16'h0000}); peek(A_PEND, got); e = sb.pop_front(); n_checks++;
    if (got !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
    cycles(1);
    sb.push_back('{"lat_pend_t2", 16'h0004}); peek(A_PEND, got); e = sb.pop_front(); n_checks++;
    if (got !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
    sb.push_back('{"lat_req_t2", 16'h0000}); got = {15'b0, interrupt_request}; e = sb.pop_front(); n_checks++;
    if (got !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
    cycles(1);
    sb.push_back('{"lat_req_t3", 16'h0001}); got = {15'b0, interrupt_request}; e = sb.pop_front(); n_checks++;
    if (got !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
    sb.push_back('{"claim_vect", 16'h8002}); bus_read(A_VECT, got); e = sb.pop_front(); n_checks++;
    if (got !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
    sb.push_back('{"claim_pend", 16'h0000}); peek(A_PEND, got); e = sb.pop_front(); n_checks++;
    if (got !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
    cycles(1);
    sb.push_back('{"claim_req", 16'h0000}); got = {15'b0, interrupt_request}; e = sb.pop_front(); n_checks++;
    if (got !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
    bus_write(A_VECT, 16'h0000);
    pulse(8'h01);
    sb.push_back('{"eoi_idle_req", 16'h0001}); got = {15'b0, interrupt_request}; e = sb.pop_front(); n_checks++;
    if (got !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
    sb.push_back('{"eoi_idle_vect", 16'h8000}); bus_read(A_VECT, got); e = sb.pop_front(); n_checks++;
    if (got !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
    bus_write(A_VECT, 16'h0000);
  endtask

  task automatic test_priority;
    bus_write(A_ENAB, 16'h00FF);
    pulse(8'h22);
    sb.push_back('{"prio_first", 16'h8001}); bus_read(A_VECT, got); e = sb.pop_front(); n_checks++;
    if (got !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
    sb.push_back('{"prio_svc_peek", 16'h8005}); bus_read(A_VECT, got); e = sb.pop_front(); n_checks++;
    if (got !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
    sb.push_back('{"prio_svc_pend", 16'h0020}); peek(A_PEND, got); e = sb.pop_front(); n_checks++;
    if (got !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
    bus_write(A_VECT, 16'h0000);
    cycles(1);
    sb.push_back('{"prio_req2", 16'h0001}); got = {15'b0, interrupt_request}; e = sb.pop_front(); n_checks++;
    if (got !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
    sb.push_back('{"prio_second", 16'h8005}); bus_read(A_VECT, got); e = sb.pop_front(); n_checks++;
    if (got !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
    bus_write(A_VECT, 16'h0000);
    sb.push_back('{"prio_empty", 16'h0000}); bus_read(A_VECT, got); e = sb.pop_front(); n_checks++;
    if (got !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
    cycles(1);
    sb.push_back('{"prio_req_off", 16'h0000}); got = {15'b0, interrupt_request}; e = sb.pop_front(); n_checks++;
    if (got !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
  endtask

  task automatic test_level;
    bus_write(A_EDGE, 16'h0000);
    irq_src[3] = 1'b1;
    cycles(4);
    sb.push_back('{"lvl_req", 16'h0001}); got = {15'b0, interrupt_request}; e = sb.pop_front(); n_checks++;
    if (got !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
    sb.push_back('{"lvl_vect", 16'h8003}); bus_read(A_VECT, got); e = sb.pop_front(); n_checks++;
    if (got !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
    bus_write(A_VECT, 16'h0000);
    cycles(1);
    sb.push_back('{"lvl_reassert", 16'h0001}); got = {15'b0, interrupt_request}; e = sb.pop_front(); n_checks++;
    if (got !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
    bus_write(A_PEND, 16'h0008);
    sb.push_back('{"lvl_w1c_noeff", 16'h0008}); peek(A_PEND, got); e = sb.pop_front(); n_checks++;
    if (got !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
    bus_write(A_ENAB, 16'h0000);
    cycles(1);
    sb.push_back('{"lvl_en_drop", 16'h0000}); got = {15'b0, interrupt_request}; e = sb.pop_front(); n_checks++;
    if (got !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
    bus_write(A_ENAB, 16'h00FF);
    irq_src[3] = 1'b0;
    cycles(4);
    sb.push_back('{"lvl_pend_drop", 16'h0000}); peek(A_PEND, got); e = sb.pop_front(); n_checks++;
    if (got !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
    sb.push_back('{"lvl_req_drop", 16'h0000}); got = {15'b0, interrupt_request}; e = sb.pop_front(); n_checks++;
    if (got !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
  endtask

  task automatic test_w1c_race;
    bus_write(A_EDGE, 16'h00FF);
    pulse(8'h10);
    sb.push_back('{"race_pre", 16'h0010}); peek(A_PEND, got); e = sb.pop_front(); n_checks++;
    if (got !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
    // Edge lands on the same clock as the W1C write below.
    irq_src[4] = 1'b1;
    cycles(1);
    bus_write(A_PEND, 16'h0010);
    sb.push_back('{"race_set_wins", 16'h0010}); peek(A_PEND, got); e = sb.pop_front(); n_checks++;
    if (got !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
    bus_write(A_PEND, 16'h0010);
    sb.push_back('{"w1c_clears", 16'h0000}); peek(A_PEND, got); e = sb.pop_front(); n_checks++;
    if (got !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
    irq_src[4] = 1'b0;
    cycles(3);
  endtask

  task automatic test_reset_mid;
    bus_write(A_ENAB, 16'h00FF);
    bus_write(A_EDGE, 16'h00FF);
    pulse(8'h04);
    sb.push_back('{"mid_claim", 16'h8002}); bus_read(A_VECT, got); e = sb.pop_front(); n_checks++;
    if (got !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
    pulse(8'h03);
    sb.push_back('{"mid_pend", 16'h0003}); peek(A_PEND, got); e = sb.pop_front(); n_checks++;
    if (got !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
    resetq = 1'b0;
    #1;
    sb.push_back('{"mid_rst_pend", 16'h0000}); peek(A_PEND, got); e = sb.pop_front(); n_checks++;
    if (got !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
    sb.push_back('{"mid_rst_edge", 16'h0000}); peek(A_EDGE, got); e = sb.pop_front(); n_checks++;
    if (got !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
    sb.push_back('{"mid_rst_vect", 16'h0000}); peek(A_VECT, got); e = sb.pop_front(); n_checks++;
    if (got !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
    sb.push_back('{"mid_rst_req", 16'h0000}); got = {15'b0, interrupt_request}; e = sb.pop_front(); n_checks++;
    if (got !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
    cycles(2);
    resetq = 1'b1;
    sb.push_back('{"mid_enab_after", 16'h0000}); bus_read(A_ENAB, got); e = sb.pop_front(); n_checks++;
    if (got !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
  endtask

`ifdef J1_IRQ_NESTING_EN
  task automatic test_nesting;
    bus_write(A_ENAB, 16'h00FF);
    bus_write(A_EDGE, 16'h00FF);
    pulse(8'h10);
    sb.push_back('{"nest_claim4", 16'h8004}); bus_read(A_VECT, got); e = sb.pop_front(); n_checks++;
    if (got !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
    cycles(1);
    sb.push_back('{"nest_req_off", 16'h0000}); got = {15'b0, interrupt_request}; e = sb.pop_front(); n_checks++;
    if (got !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
    pulse(8'h02);
    sb.push_back('{"nest_preempt_req", 16'h0001}); got = {15'b0, interrupt_request}; e = sb.pop_front(); n_checks++;
    if (got !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
    sb.push_back('{"nest_claim1", 16'h8001}); bus_read(A_VECT, got); e = sb.pop_front(); n_checks++;
    if (got !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
    pulse(8'h40);
    sb.push_back('{"nest_blocked", 16'h0000}); got = {15'b0, interrupt_request}; e = sb.pop_front(); n_checks++;
    if (got !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
    sb.push_back('{"nest_blocked_vect", 16'h0000}); peek(A_VECT, got); e = sb.pop_front(); n_checks++;
    if (got !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
    bus_write(A_VECT, 16'h0000);
    cycles(2);
    sb.push_back('{"nest_eoi1", 16'h0000}); got = {15'b0, interrupt_request}; e = sb.pop_front(); n_checks++;
    if (got !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
    bus_write(A_VECT, 16'h0000);
    cycles(2);
    sb.push_back('{"nest_eoi2", 16'h0001}); got = {15'b0, interrupt_request}; e = sb.pop_front(); n_checks++;
    if (got !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
    sb.push_back('{"nest_claim6", 16'h8006}); bus_read(A_VECT, got); e = sb.pop_front(); n_checks++;
    if (got !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
    bus_write(A_VECT, 16'h0000);
  endtask
`endif

  initial begin
    resetq = 1'b0;
    cycles(3);
    test_reset();
    resetq = 1'b1;
    cycles(1);
`ifdef J1_IRQ_NESTING_EN
    test_nesting();
`else
    test_basic();
    test_priority();
    test_level();
    test_w1c_race();
`endif
    test_reset_mid();
    if (sb.size() != 0) begin
      n_checks++;
      n_err++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
